// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive controller for the serial packet front end. It sits between the
// start-bit edge detector and the RX data buffer. For each start pulse accepted
// in IDLE it times the bit cells, samples the line mid-cell, shifts in the data
// bits LSB first, checks the optional parity bit and the stop bit(s), and then
// hands the character to the buffer with a one-cycle load pulse.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit period (>= 4)
//   DATA_BITS     data bits per character (5..9)
//   PARITY_MODE   0 = none, 1 = even, 2 = odd
//   STOP_BITS     stop bits per character (1 or 2)
//
// Ports:
//   clk                 system clock
//   n_rst               asynchronous active-low reset
//   start_bit_detected  one-cycle pulse from the edge detector, honoured in IDLE only
//   serial_in           synchronised serial line, idle level 1
//   rx_data             last received character, held until the next load
//   load_buffer         one-cycle pulse, rx_data valid for the buffer
//   busy                high in every state except IDLE
//   framing_error       sticky, set when any stop sample is 0
//   parity_error        sticky, set on parity mismatch
//   bit_index           index of the current data bit, 0 outside DATA
//
// Build option:
//   RX_ERR_DISCARD_EN   when defined, a frame that ends with either error flag
//                       set does not pulse load_buffer and leaves rx_data
//                       unchanged; the LOAD cycle and the flags are unaffected.
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_bit_detected,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 load_buffer,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic [3:0]           bit_index
);

    localparam int              HALF     = CLKS_PER_BIT / 2;
    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_LOAD
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 stop_cnt;
    logic                 sample;
    logic                 par_x;
    logic                 parity_bad;
    logic                 stop_bad;
    logic                 accept_start;
    logic                 enter_load;
    logic                 do_load;

    // The line is sampled when the bit timer has run down.
    assign sample       = (cnt == '0);
    assign accept_start = (state == S_IDLE) && start_bit_detected;
    assign stop_bad     = (state == S_STOP) && sample && !serial_in;
    assign enter_load   = (state == S_STOP) && (next_state == S_LOAD);

    // XOR over the received data bits and the parity sample: even parity
    // expects 0, odd parity expects 1.
    assign par_x = (^shift_reg) ^ serial_in;

    always_comb begin
        parity_bad = 1'b0;
        if (PARITY_MODE == 1) begin
            parity_bad = par_x;
        end else if (PARITY_MODE == 2) begin
            parity_bad = ~par_x;
        end
    end

`ifdef RX_ERR_DISCARD_EN
    // Include the error seen at the final stop sample, which is only
    // registered on the same edge that enters LOAD.
    assign do_load = enter_load & ~(framing_error | parity_error | stop_bad);
`else
    assign do_load = enter_load;
`endif

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and decoded outputs
    always_comb begin
        next_state = state;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_bit_detected) begin
                    next_state = S_START;
                end
            end
            S_START: begin
                // A line back at 1 by mid start bit was a glitch.
                if (sample) begin
                    next_state = serial_in ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample && (bit_index == LAST_BIT)) begin
                    next_state = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (sample) begin
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (sample && (stop_cnt == LAST_STOP)) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Bit timer, shift register, counters, flags and buffer interface
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt           <= '0;
            shift_reg     <= '0;
            stop_cnt      <= 1'b0;
            bit_index     <= 4'd0;
            rx_data       <= '0;
            load_buffer   <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
        end else begin
            load_buffer <= do_load;

            case (state)
                S_IDLE: begin
                    if (start_bit_detected) begin
                        cnt <= CNT_HALF;
                    end
                end
                S_START, S_DATA, S_PARITY, S_STOP: begin
                    cnt <= sample ? CNT_FULL : cnt - 1'b1;
                end
                default: begin
                end
            endcase

            if (accept_start) begin
                shift_reg     <= '0;
                framing_error <= 1'b0;
                parity_error  <= 1'b0;
            end

            if ((state == S_DATA) && sample) begin
                shift_reg <= {serial_in, shift_reg[DATA_BITS-1:1]};
                bit_index <= (bit_index == LAST_BIT) ? 4'd0 : bit_index + 4'd1;
            end

            if ((state == S_PARITY) && sample && parity_bad) begin
                parity_error <= 1'b1;
            end

            if ((state == S_STOP) && sample) begin
                stop_cnt <= enter_load ? 1'b0 : ~stop_cnt;
            end

            if (stop_bad) begin
                framing_error <= 1'b1;
            end

            if (do_load) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Four receiver instances in different frame formats share clock and reset.
// Each frame is built as a list of line bits (start, data LSB first, parity,
// stops), each held for one bit period from the start pulse. The expected
// per-cycle outputs follow from the frame timing rules: start sample at H,
// sample j at H + j*CLKS_PER_BIT, load at H + (DATA+P+STOP)*CLKS_PER_BIT + 1.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    function automatic int cfg_c(input int i);
        case (i)
            0:       return 10;
            1:       return 8;
            2:       return 4;
            default: return 7;
        endcase
    endfunction

    function automatic int cfg_d(input int i);
        case (i)
            0:       return 8;
            1:       return 7;
            2:       return 8;
            default: return 9;
        endcase
    endfunction

    function automatic int cfg_p(input int i);
        case (i)
            0:       return 0;
            1:       return 1;
            2:       return 0;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0:       return 1;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

`ifdef RX_ERR_DISCARD_EN
    localparam bit DISCARD = 1'b1;
`else
    localparam bit DISCARD = 1'b0;
`endif

    logic       clk;
    logic       n_rst;
    logic       start_v [4];
    logic       ser_v   [4];
    logic       lb_v    [4];
    logic       busy_v  [4];
    logic       fe_v    [4];
    logic       pe_v    [4];
    logic [3:0] bi_v    [4];
    logic [8:0] rx_v    [4];
    logic [8:0] exp_rx  [4];

    int n_total;
    int n_bad;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [cfg_d(g)-1:0] rxd;

        uart_rx_ctrl #(
            .CLKS_PER_BIT (cfg_c(g)),
            .DATA_BITS    (cfg_d(g)),
            .PARITY_MODE  (cfg_p(g)),
            .STOP_BITS    (cfg_s(g))
        ) dut (
            .clk                (clk),
            .n_rst              (n_rst),
            .start_bit_detected (start_v[g]),
            .serial_in          (ser_v[g]),
            .rx_data            (rxd),
            .load_buffer        (lb_v[g]),
            .busy               (busy_v[g]),
            .framing_error      (fe_v[g]),
            .parity_error       (pe_v[g]),
            .bit_index          (bi_v[g])
        );

        assign rx_v[g] = 9'(rxd);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input int id, input string when);
        check_val($sformatf("%s d%0d busy", when, id), 32'(busy_v[id]), 32'd0);
        check_val($sformatf("%s d%0d load", when, id), 32'(lb_v[id]), 32'd0);
        check_val($sformatf("%s d%0d ferr", when, id), 32'(fe_v[id]), 32'd0);
        check_val($sformatf("%s d%0d perr", when, id), 32'(pe_v[id]), 32'd0);
        check_val($sformatf("%s d%0d bidx", when, id), 32'(bi_v[id]), 32'd0);
        check_val($sformatf("%s d%0d rxd", when, id), 32'(rx_v[id]), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                start_v[j] = 1'b0;
                ser_v[j]   = 1'b1;
            end
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                check_val($sformatf("idle d%0d busy", j), 32'(busy_v[j]), 32'd0);
                check_val($sformatf("idle d%0d load", j), 32'(lb_v[j]), 32'd0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // glitch_in: -1 none, 0 random return-to-1 cycle in 1..H, >0 that cycle.
    // xmode: 0 no extra start pulse, 1 extra pulse in the LOAD cycle,
    //        2 extra pulse at a random busy cycle.
    // rst_at: cycle at which reset is pulsed mid-frame, -1 for none.
    task automatic run_frame(input int id, input logic [8:0] data_in, input bit bad_par,
                             input logic [1:0] stops, input int glitch_in, input int xmode,
                             input int rst_at);
        int         c, d, p, s, h, n, lc, last, glitch_at, extra_at, fe_first, busy_end;
        bit         q[$];
        logic [8:0] data;
        bit         xd, pbit, par_bad, discard, glitch;
        logic       exp_busy, exp_lb, exp_pe, exp_fe;
        int         exp_bi;

        c  = cfg_c(id);
        d  = cfg_d(id);
        p  = (cfg_p(id) != 0) ? 1 : 0;
        s  = cfg_s(id);
        h  = c / 2;
        n  = d + p + s;
        lc = h + n * c + 1;

        data = data_in & 9'((1 << d) - 1);
        q    = {};
        q.push_back(1'b0);
        xd = 1'b0;
        for (int k = 0; k < d; k++) begin
            q.push_back(data[k]);
            xd ^= data[k];
        end
        par_bad = 1'b0;
        if (p == 1) begin
            pbit = (cfg_p(id) == 1) ? xd : ~xd;
            if (bad_par) pbit = ~pbit;
            q.push_back(pbit);
            par_bad = (cfg_p(id) == 1) ? (xd ^ pbit) : ~(xd ^ pbit);
        end
        fe_first = -1;
        for (int k = 0; k < s; k++) begin
            q.push_back(stops[k]);
            if (!stops[k] && fe_first < 0) fe_first = h + (d + p + k + 1) * c;
        end

        glitch    = (glitch_in >= 0);
        glitch_at = (glitch_in == 0) ? int'($urandom_range(1, h)) : glitch_in;
        discard   = DISCARD && (par_bad || fe_first >= 0);
        extra_at  = (xmode == 1) ? lc : (xmode == 2) ? int'($urandom_range(1, lc - 1)) : -1;
        last      = glitch ? h + 1 : lc;
        busy_end  = glitch ? h : lc;

        for (int t = 0; t <= last; t++) begin
            start_v[id] = (t == 0) || (t == extra_at);
            if (glitch) ser_v[id] = (t < glitch_at) ? 1'b0 : 1'b1;
            else        ser_v[id] = (t < lc) ? q[t / c] : 1'b1;

            if (t == rst_at) begin
                #1 n_rst = 1'b0;
                #1;
                for (int j = 0; j < 4; j++) begin
                    exp_rx[j] = 9'd0;
                    check_zero(j, "midrst");
                end
                start_v[id] = 1'b0;
                ser_v[id]   = 1'b1;
                @(negedge clk);
                n_rst = 1'b1;
                @(posedge clk);
                #1;
                return;
            end

            @(negedge clk);
            exp_busy = (t >= 1) && (t <= busy_end);
            exp_lb   = !glitch && (t == lc) && !discard;
            if (exp_lb) exp_rx[id] = data;
            exp_bi   = (!glitch && t >= h + 1 && t <= h + d * c) ? (t - h - 1) / c : 0;
            check_val($sformatf("d%0d t%0d busy", id, t), 32'(busy_v[id]), 32'(exp_busy));
            check_val($sformatf("d%0d t%0d load", id, t), 32'(lb_v[id]), 32'(exp_lb));
            check_val($sformatf("d%0d t%0d bidx", id, t), 32'(bi_v[id]), 32'(exp_bi));
            check_val($sformatf("d%0d t%0d rxd", id, t), 32'(rx_v[id]), 32'(exp_rx[id]));
            if (t >= 1) begin
                exp_pe = !glitch && par_bad && (t > h + (d + 1) * c);
                exp_fe = !glitch && (fe_first >= 0) && (t > fe_first);
                check_val($sformatf("d%0d t%0d perr", id, t), 32'(pe_v[id]), 32'(exp_pe));
                check_val($sformatf("d%0d t%0d ferr", id, t), 32'(fe_v[id]), 32'(exp_fe));
            end
            @(posedge clk);
            #1;
        end
        start_v[id] = 1'b0;
        ser_v[id]   = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        n_rst   = 1'b0;
        for (int j = 0; j < 4; j++) begin
            start_v[j] = 1'b0;
            ser_v[j]   = 1'b1;
            exp_rx[j]  = 9'd0;
        end

        @(negedge clk);
        for (int j = 0; j < 4; j++) check_zero(j, "reset");
        #2 n_rst = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(2);

        // 8N1 clean byte, then a start glitch
        run_frame(0, 9'h0A5, 1'b0, 2'b11, -1, 0, -1);
        run_frame(0, 9'h000, 1'b0, 2'b11, 5, 0, -1);
        idle_cycles(1);

        // 7E1 with wrong parity bit, then clean
        run_frame(1, 9'h055, 1'b1, 2'b11, -1, 0, -1);
        run_frame(1, 9'h055, 1'b0, 2'b11, -1, 0, -1);

        // 8N2: second stop 0, clean, first stop only 0
        run_frame(2, 9'h03C, 1'b0, 2'b01, -1, 0, -1);
        run_frame(2, 9'h03C, 1'b0, 2'b11, -1, 0, -1);
        run_frame(2, 9'h03C, 1'b0, 2'b10, -1, 0, -1);
        run_frame(2, 9'h0C3, 1'b0, 2'b11, -1, 0, -1);

        // 9O2: bit_index reaches 8, clean then wrong parity
        run_frame(3, 9'h1A5, 1'b0, 2'b11, -1, 0, -1);
        run_frame(3, 9'h15A, 1'b1, 2'b11, -1, 0, -1);

        // Reset during data bit 4, then a full 0xFF frame
        run_frame(0, 9'h05A, 1'b0, 2'b11, -1, 0, 5 + 5 * 10 - 3);
        run_frame(0, 9'h0FF, 1'b0, 2'b11, -1, 0, -1);

        // Extra start pulses while busy and in the LOAD cycle
        run_frame(0, 9'h096, 1'b0, 2'b11, -1, 2, -1);
        run_frame(0, 9'h069, 1'b0, 2'b11, -1, 1, -1);
        run_frame(0, 9'h033, 1'b0, 2'b11, -1, 0, -1);

        for (int i = 0; i < 48; i++) begin
            int         id;
            logic [8:0] dat;
            logic [1:0] st;
            bit         bp;
            int         gl;
            id  = int'($urandom_range(0, 3));
            dat = 9'($urandom);
            st  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            bp  = ($urandom_range(0, 3) == 0);
            gl  = ($urandom_range(0, 7) == 0) ? 0 : -1;
            idle_cycles(int'($urandom_range(0, 2)));
            run_frame(id, dat, bp, st, gl, (gl < 0) ? int'($urandom_range(0, 2)) : 0, -1);
        end

        idle_cycles(3);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
